freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Digital frequency meter: counts rising edges of an asynchronous input signal over a programmable gate window of reference-clock cycles.
- Reports the count as a frequency code. It is the measuring counterpart to the team's VCO, which converts a control word into a clock.
- Sits in the clock-monitoring and PLL-calibration path: VCO output enters on sig_i, and count_o feeds the control-word search loop.

Parameters:
- COUNT_W, 20, width of edge count / frequency code (matches VCO control-word resolution)
- GATE_W, 24, width of gate-length input, in reference clock cycles
- SYNC_STAGES, 2, flop stages in the sig_i synchronizer (legal range 2..4)

Ports:
- clk_i  input  1  reference clock
- arst_ni  input  1  asynchronous active-low reset
- sig_i  input  1  asynchronous signal under measurement
- gate_len_i  input  GATE_W  window length in clk_i cycles; sampled at window start
- start_i  input  1  begin a measurement (honoured only in IDLE)
- continuous_i  input  1  when 1, a new window starts back-to-back after each completion
- abort_i  input  1  terminate the current window without a result
- busy_o  output  1  high while a window is open
- count_o  output  COUNT_W  rising-edge count of the last completed window
- valid_o  output  1  one-cycle pulse: count_o and overflow_o updated
- overflow_o  output  1  last completed window saturated the counter

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (arst_ni). Reset clears the synchronizer, edge-detect history, all counters and state.
  - Reset values: state=IDLE, busy_o=0, count_o=0, valid_o=0, overflow_o=0.
  - Reset mid-window discards the window; no valid_o is produced.
- Synchronizer: sig_i passes through SYNC_STAGES flops, then one history flop. A rising edge is detected when the synchronized value is 1 and the history value is 0.
  - Detection latency is SYNC_STAGES+1 cycles.
  - Input high and low phases must each be at least 1 clk_i period; faster inputs are undercounted, with no error flag.
- FSM states: IDLE, MEASURE.
  - IDLE -> MEASURE: on start_i=1 at a clock edge. On that edge the block latches gate_len_i into gate_cnt (a value of 0 is treated as 1), clears edge_cnt and the window overflow flag, and sets busy_o=1.
  - MEASURE: each cycle, if an edge is detected, edge_cnt increments. gate_cnt decrements each cycle. The window is exactly gate_len cycles, and edges detected in any of those cycles, including the last, are counted.
  - Window end (gate_cnt==1): count_o gets the final edge_cnt, including a same-cycle edge. overflow_o gets the window flag. valid_o=1 for the following cycle.
    - If continuous_i=1 at that edge, the block stays in MEASURE and relatches gate_len_i. The new window's first cycle is the next cycle, with no gap and no lost edges.
    - Otherwise the block goes to IDLE and busy_o=0.
- Timing with start at edge 0: MEASURE spans cycles 1..N, and valid_o is high in cycle N+1. In continuous mode, valid_o pulses are spaced exactly N cycles apart.
- Saturation: edge_cnt holds at 2^COUNT_W-1. An edge arriving at that value sets the window overflow flag. The flag is reported only at window end.
- abort_i in MEASURE goes to IDLE next cycle. No valid_o is produced, and count_o and overflow_o keep their previous values. abort_i has priority over window end and over continuous restart. abort_i in IDLE is ignored.
- start_i in MEASURE is ignored. gate_len_i changes mid-window do not affect the current window.
- count_o and overflow_o are registered and hold until the next completed window.

Decomposition:
- Package freq_meter_pkg holds:
  - state enum type (IDLE, MEASURE)
  - localparam for the count saturation value
- Sub-module sig_sync_edge: parameterized SYNC_STAGES synchronizer plus rising-edge pulse output, on the same clock and reset. It is reusable across the clock-monitor blocks.

Test Plan:
- sig_i rising every 10 cycles (long steady run), gate_len_i=100, start_i pulse -> valid_o after exactly 101 cycles, count_o=10, overflow_o=0, busy_o high for 100 cycles.
- gate_len_i=0, sig_i constant 0 -> window of 1 cycle, valid_o at cycle 2, count_o=0.
- COUNT_W=4, sig_i period 4, gate_len_i=100 -> count_o=15, overflow_o=1. A following window with gate_len_i=8 -> overflow_o=0, count_o=2.
- continuous_i=1, gate_len_i=50, sig_i period 5 -> valid_o pulses exactly 50 cycles apart, each with count_o=10. Total edges across windows equals the total generated (no loss at boundaries).
- abort_i at cycle 20 of a 100-cycle window -> busy_o low next cycle, no valid_o, count_o unchanged from prior result. start_i then restarts normally.
- arst_ni low mid-window -> all outputs 0 immediately. After release, start_i with gate 100 and sig period 10 -> count_o=10.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    // Measurement controller states.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // Default widths for the counter, the gate length and the synchronizer depth.
    localparam int FM_COUNT_W     = 20;
    localparam int FM_GATE_W      = 24;
    localparam int FM_SYNC_STAGES = 2;

    // Source of the count saturation value. The counter takes its low COUNT_W bits,
    // so COUNT_W may be at most 32.
    localparam logic [31:0] COUNT_SAT_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input.
// A history flop follows the last stage, and the block emits a one-cycle
// pulse on each rising edge of the synchronized signal.
module sig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the input through the synchronizer chain, then into the history flop.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter.
// The block counts rising edges of sig_i over a window of gate_len_i
// reference cycles. It reports the count and a saturation flag with a
// one-cycle valid pulse.
//
// Control semantics: start_i, abort_i and continuous_i are level-sampled on
// clock edges with no back-pressure. valid_o is a strobe with no ready: the
// result is also held on count_o and overflow_o until the next completed
// window, so a consumer that misses the pulse still sees the last value.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int COUNT_W     = FM_COUNT_W,
    parameter int GATE_W      = FM_GATE_W,
    parameter int SYNC_STAGES = FM_SYNC_STAGES
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               sig_i,
    input  logic [GATE_W-1:0]  gate_len_i,
    input  logic               start_i,
    input  logic               continuous_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               valid_o,
    output logic               overflow_o,
    output logic               state_o
);

    localparam logic [COUNT_W-1:0] CNT_SAT = COUNT_SAT_ALL_ONES[COUNT_W-1:0];

    state_e             state_q;
    logic [GATE_W-1:0]  gate_cnt;
    logic [GATE_W-1:0]  gate_load;
    logic [COUNT_W-1:0] edge_cnt;
    logic [COUNT_W-1:0] cnt_nxt;
    logic               win_ovf;
    logic               ovf_nxt;
    logic               rise;

    sig_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .sig_i   (sig_i),
        .rise_o  (rise)
    );

    // A zero gate length still opens a one-cycle window.
    assign gate_load = (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;

    // Edge count after this cycle's edge. It saturates, and it flags an edge that arrives at the ceiling.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = win_ovf;
        if (rise) begin
            if (edge_cnt == CNT_SAT) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = edge_cnt + COUNT_W'(1);
            end
        end
    end

    // Measurement controller: open the window, count edges, publish the result, then restart or idle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            win_ovf    <= 1'b0;
            busy_o     <= 1'b0;
            count_o    <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= MEASURE;
                        gate_cnt <= gate_load;
                        edge_cnt <= '0;
                        win_ovf  <= 1'b0;
                        busy_o   <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else if (gate_cnt == GATE_W'(1)) begin
                        count_o    <= cnt_nxt;
                        overflow_o <= ovf_nxt;
                        valid_o    <= 1'b1;
                        if (continuous_i) begin
                            gate_cnt <= gate_load;
                            edge_cnt <= '0;
                            win_ovf  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                        edge_cnt <= cnt_nxt;
                        win_ovf  <= ovf_nxt;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a window-level reference model is
// compared every cycle, alongside directed scenarios with literal expectations.
module tb_freq_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        sig = 1'b0;
    logic [23:0] gate_len = '0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        cont = 1'b0;
    logic        abort = 1'b0;

    logic        busy, valid, ovf, state;
    logic [19:0] count;
    logic        busy4, valid4, ovf4, state4;
    logic [3:0]  count4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    freq_meter dut (
        .clk_i(clk), .arst_ni(arst_n), .sig_i(sig), .gate_len_i(gate_len),
        .start_i(start), .continuous_i(cont), .abort_i(abort),
        .busy_o(busy), .count_o(count), .valid_o(valid), .overflow_o(ovf),
        .state_o(state)
    );

    freq_meter #(.COUNT_W(4)) dut4 (
        .clk_i(clk), .arst_ni(arst_n), .sig_i(sig), .gate_len_i(gate_len),
        .start_i(start4), .continuous_i(cont), .abort_i(abort),
        .busy_o(busy4), .count_o(count4), .valid_o(valid4), .overflow_o(ovf4),
        .state_o(state4)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus: periodic signal ----------------
    int sig_period = 0;
    initial begin : sig_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (sig_period == 0) begin
                sig = 1'b0;
                ph  = 0;
            end else begin
                ph  = (ph + 1) % sig_period;
                sig = (ph < sig_period / 2);
            end
        end
    end

    // ---------------- reference model ----------------
    // The model views a measurement as a window that ends at an absolute clock
    // index. An input rise sampled at edge j is seen S edges later.
    typedef struct {
        bit     open;
        longint end_k;
        int     cnt;
        bit     wovf;
        int     exp_count;
        bit     exp_ovf;
        bit     exp_valid;
    } model_t;

    function automatic model_t step(model_t mi, bit st, bit ab, bit cn, int len,
                                    int maxv, bit det, longint k);
        model_t m;
        int     eff;
        m = mi;
        m.exp_valid = 1'b0;
        eff = (len == 0) ? 1 : len;
        if (!m.open) begin
            if (st) begin
                m.open  = 1'b1;
                m.end_k = k + eff;
                m.cnt   = 0;
                m.wovf  = 1'b0;
            end
        end else if (ab) begin
            m.open = 1'b0;
        end else begin
            if (det) begin
                if (m.cnt == maxv) m.wovf = 1'b1;
                else m.cnt++;
            end
            if (k == m.end_k) begin
                m.exp_count = m.cnt;
                m.exp_ovf   = m.wovf;
                m.exp_valid = 1'b1;
                if (cn) begin
                    m.end_k = k + eff;
                    m.cnt   = 0;
                    m.wovf  = 1'b0;
                end else begin
                    m.open = 1'b0;
                end
            end
        end
        return m;
    endfunction

    model_t m1 = '{default: 0};
    model_t m4 = '{default: 0};
    bit     samp[$] = '{0, 0, 0};
    longint kk = 0;
    bit     det;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m1 = '{default: 0};
            m4 = '{default: 0};
            samp.delete();
            for (int i = 0; i <= S; i++) samp.push_back(1'b0);
        end else begin
            kk++;
            det = samp[S-1] & ~samp[S];
            m1 = step(m1, start, abort, cont, int'(gate_len), 20'hFFFFF, det, kk);
            m4 = step(m4, start4, abort, cont, int'(gate_len), 15, det, kk);
            samp.push_front(sig);
            void'(samp.pop_back());
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("busy",   busy,   m1.open);
            check("state",  state,  m1.open);
            check("valid",  valid,  m1.exp_valid);
            check("count",  count,  m1.exp_count);
            check("ovf",    ovf,    m1.exp_ovf);
            check("busy4",  busy4,  m4.open);
            check("state4", state4, m4.open);
            check("valid4", valid4, m4.exp_valid);
            check("count4", count4, m4.exp_count);
            check("ovf4",   ovf4,   m4.exp_ovf);
        end
    end

    // ---------------- driver tasks ----------------
    // This task is called at a negedge. It starts a window and returns at the
    // negedge where valid is seen. lat is the cycle number after the start
    // edge (0 means valid never came).
    task automatic measure(input bit use4, input int limit, output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        if (use4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start  = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            if (use4 ? busy4 : busy) busy_cyc++;
            if (use4 ? valid4 : valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int lat, bc, prev, nvalid, sum;
        int vcyc[$];

        #1 arst_n = 1'b0;
        cycles(3);
        check("rst_busy",  busy,  0);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf",   ovf,   0);
        arst_n = 1'b1;
        cycles(2);

        // Period-10 signal, 100-cycle window.
        sig_period = 10;
        gate_len   = 24'd100;
        cycles(30);
        measure(0, 150, lat, bc);
        check("t1_latency", lat, 101);
        check("t1_busy_cycles", bc, 100);
        check("t1_count", count, 10);
        check("t1_ovf", ovf, 0);
        cycles(3);

        // Zero gate length gives a one-cycle window.
        sig_period = 0;
        cycles(6);
        gate_len = 24'd0;
        measure(0, 20, lat, bc);
        check("t2_latency", lat, 2);
        check("t2_busy_cycles", bc, 1);
        check("t2_count", count, 0);
        cycles(3);

        // Saturation on the 4-bit instance, then a clean short window.
        sig_period = 4;
        gate_len   = 24'd100;
        cycles(8);
        measure(1, 150, lat, bc);
        check("t3_latency", lat, 101);
        check("t3_count", count4, 15);
        check("t3_ovf", ovf4, 1);
        cycles(2);
        gate_len = 24'd8;
        measure(1, 30, lat, bc);
        check("t3b_latency", lat, 9);
        check("t3b_count", count4, 2);
        check("t3b_ovf", ovf4, 0);
        cycles(3);

        // Continuous back-to-back windows.
        sig_period = 5;
        gate_len   = 24'd50;
        cont       = 1'b1;
        cycles(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sum = 0;
        for (int i = 1; i <= 260 && vcyc.size() < 4; i++) begin
            if (valid) begin
                vcyc.push_back(i);
                sum += int'(count);
                check("t4_count", count, 10);
            end
            @(negedge clk);
        end
        cont = 1'b0;
        check("t4_pulses", vcyc.size(), 4);
        if (vcyc.size() == 4) begin
            check("t4_first", vcyc[0], 51);
            for (int j = 1; j < 4; j++) check("t4_spacing", vcyc[j] - vcyc[j-1], 50);
        end
        check("t4_sum", sum, 40);
        for (int i = 0; i < 80 && busy; i++) @(negedge clk);
        check("t4_idle", busy, 0);
        cycles(3);

        // Abort in cycle 20 of a 100-cycle window.
        sig_period = 10;
        gate_len   = 24'd100;
        cycles(20);
        prev = int'(count);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(19);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        nvalid = 0;
        for (int i = 0; i < 110; i++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        check("t5_no_valid", nvalid, 0);
        check("t5_count_held", count, prev);
        measure(0, 150, lat, bc);
        check("t5_restart_latency", lat, 101);
        check("t5_restart_count", count, 10);
        cycles(3);

        // Asynchronous reset mid-window.
        measure(0, 150, lat, bc);
        cycles(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(30);
        #2 arst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_count", count, 0);
        check("t6_valid", valid, 0);
        check("t6_ovf", ovf, 0);
        check("t6_state", state, 0);
        cycles(3);
        arst_n = 1'b1;
        cycles(20);
        measure(0, 150, lat, bc);
        check("t6_latency", lat, 101);
        check("t6_count_after", count, 10);
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
